// File: rtl/generic_bus_ram_responder_pkg.sv
// Shared types and helpers for the generic_bus RAM responder.
package generic_bus_ram_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} gb_ram_state_t;

  localparam logic [31:0] BAD_DATA = 32'hBAD0_BAD0;

  // Expands a 4-bit lane enable into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] byte_en);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{byte_en[i]}};
    return m;
  endfunction

endpackage

// File: rtl/generic_bus_ram_responder_if.sv
// Generic request/busy bus between one requestor and one responder.
interface generic_bus_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        ren;
  logic        wen;
  logic [31:0] rdata;
  logic        busy;

  modport generic_bus (input addr, wdata, byte_en, ren, wen, output rdata, busy);
  modport slave       (input addr, wdata, byte_en, ren, wen, output rdata, busy);
  modport master      (output addr, wdata, byte_en, ren, wen, input rdata, busy);

endinterface

// File: rtl/generic_bus_ram_responder_lfsr.sv
// Random stall generator; only built when GENERIC_BUS_RAM_RAND_STALL_EN is defined.
`ifdef GENERIC_BUS_RAM_RAND_STALL_EN
module gb_stall_lfsr (
  input  logic       CLK,
  input  logic       RST,
  input  logic       advance_i,
  output logic [1:0] stall_o
);

  logic [15:0] lfsr_q;

  // Maximal-length 16-bit Fibonacci LFSR, stepped once per accepted transaction.
  always_ff @(posedge CLK) begin
    if (RST) lfsr_q <= 16'hACE1;
    else if (advance_i)
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall_o = lfsr_q[1:0];

endmodule
`endif

// File: rtl/generic_bus_ram_responder.sv
// Word-addressed SRAM responder on generic_bus_if with programmable wait states.
// Define GENERIC_BUS_RAM_RAND_STALL_EN to add 0..3 random extra wait cycles per access.
module generic_bus_ram_responder
  import generic_bus_ram_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic                 CLK,
  input logic                 RST,
  generic_bus_if.generic_bus  gbif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [4:0]  LAT_W   = 5'(LATENCY);

  logic [31:0]   mem [DEPTH];

  gb_ram_state_t state_q;
  logic [4:0]    cnt_q;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    byteEn_q;
  logic          opWrite_q;
  logic          busy_q;
  logic [31:0]   rdata_q;

  logic          accept;
  logic          abort;
  logic [4:0]    cntLoad;
  logic [29:0]   wordAddr;
  logic [29:0]   wordOff;
  logic          inRange;
  logic [AW-1:0] idx;
  logic          memWe;

  assign accept = (state_q == IDLE) && (gbif.ren || gbif.wen);
  assign abort  = !gbif.ren && !gbif.wen;

  // In IDLE the live address is decoded so a zero-latency read can load rdata on acceptance.
  assign wordAddr = (state_q == IDLE) ? gbif.addr[31:2] : addr_q;
  assign wordOff  = wordAddr - BASE_ADDR[31:2];
  assign inRange  = wordOff < DEPTH_W;
  assign idx      = wordOff[AW-1:0];

`ifdef GENERIC_BUS_RAM_RAND_STALL_EN
  logic [1:0] stall;

  gb_stall_lfsr u_stall (
    .CLK       (CLK),
    .RST       (RST),
    .advance_i (accept),
    .stall_o   (stall)
  );

  assign cntLoad = LAT_W + {3'b000, stall};
`else
  assign cntLoad = LAT_W;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      busy_q  <= 1'b1;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q    <= gbif.addr[31:2];
            wdata_q   <= gbif.wdata;
            byteEn_q  <= gbif.byte_en;
            opWrite_q <= gbif.wen;
            cnt_q     <= cntLoad;
            if (cntLoad == 5'd0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              rdata_q <= inRange ? mem[idx] : BAD_DATA;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              rdata_q <= inRange ? mem[idx] : BAD_DATA;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Writes land on the edge that leaves DONE, so rdata captured on entry is the pre-write word.
  assign memWe = (state_q == DONE) && opWrite_q && inRange && !RST;

  always_ff @(posedge CLK) begin
    if (memWe) mem[idx] <= (mem[idx] & ~byte_mask(byteEn_q)) | (wdata_q & byte_mask(byteEn_q));
  end

  assign gbif.busy  = busy_q;
  assign gbif.rdata = rdata_q;

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized run
// against a word-array reference model, for a LATENCY=2 and a LATENCY=0 instance.
module tb_generic_bus_ram_responder;

  localparam int          LAT_A  = 2;
  localparam int          LAT_B  = 0;
  localparam logic [31:0] BASE_B = 32'h1000_0000;
  localparam logic [31:0] BAD    = 32'hBAD0_BAD0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic        chkRd;
    logic [31:0] expRdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [3:0]  reqBe = '0;
  logic        reqRen = 1'b0;
  logic        reqWen = 1'b0;
  int          sel = 0;
  logic        curBusy;
  logic [31:0] curRdata;

  int compared = 0;
  int mismatched = 0;

  vec_t        vecs[$];
  logic [31:0] modelMem [32];

  always #5 clk = ~clk;

  generic_bus_if busA();
  generic_bus_if busB();

  assign busA.addr    = reqAddr;
  assign busA.wdata   = reqWdata;
  assign busA.byte_en = reqBe;
  assign busA.ren     = reqRen && (sel == 0);
  assign busA.wen     = reqWen && (sel == 0);
  assign busB.addr    = reqAddr;
  assign busB.wdata   = reqWdata;
  assign busB.byte_en = reqBe;
  assign busB.ren     = reqRen && (sel == 1);
  assign busB.wen     = reqWen && (sel == 1);
  assign curBusy      = (sel == 0) ? busA.busy : busB.busy;
  assign curRdata     = (sel == 0) ? busA.rdata : busB.rdata;

  generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(LAT_A), .BASE_ADDR(32'h0)) dutA (
    .CLK  (clk),
    .RST  (rst),
    .gbif (busA)
  );

  generic_bus_ram_responder #(.DEPTH(16), .LATENCY(LAT_B), .BASE_ADDR(BASE_B)) dutB (
    .CLK  (clk),
    .RST  (rst),
    .gbif (busB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkLatency(input string name, input int lat, input int base);
    compared++;
`ifdef GENERIC_BUS_RAM_RAND_STALL_EN
    if (!(lat >= base + 1 && lat <= base + 4)) begin
      mismatched++;
      $display("[TB] FAIL %s: latency %0d, expected %0d..%0d", name, lat, base + 1, base + 4);
    end
`else
    if (lat != base + 1) begin
      mismatched++;
      $display("[TB] FAIL %s: latency %0d, expected %0d", name, lat, base + 1);
    end
`endif
  endtask

  // One full transaction: request held until busy drops, then released through the DONE exit edge.
  task automatic applyStimulus(input int which, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic rd, input logic wr,
                               output logic [31:0] rdOut, output int lat);
    @(negedge clk);
    sel = which; reqAddr = a; reqWdata = d; reqBe = be; reqRen = rd; reqWen = wr;
    lat = 0;
    rdOut = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!curBusy) begin
        lat = c;
        rdOut = curRdata;
        break;
      end
    end
    reqRen = 1'b0;
    reqWen = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        sawLow;

    vecs.push_back('{32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h10,   32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{32'h20,   32'h11223344, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h20,   32'hAABBCCDD, 4'h5, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h20,   32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h11BB33DD});
    vecs.push_back('{32'h1000, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, BAD});
    vecs.push_back('{32'h0,    32'h12345678, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h0,    32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h12345678});
    vecs.push_back('{32'h12,   32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h10,   32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{32'h10,   32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{32'h13,   32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D});
    vecs.push_back('{32'h30,   32'h30303030, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h40,   32'h40404040, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busyA", 32'(busA.busy), 32'h1);
    checkOutput("reset rdataA", busA.rdata, 32'h0);
    checkOutput("reset busyB", 32'(busB.busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].rd, vecs[i].wr, rd, lat);
      checkLatency($sformatf("vec%0d latency", i), lat, LAT_A);
      if (vecs[i].chkRd) checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRdata);
    end

    // Abort: read released after one wait cycle must never complete.
    @(negedge clk);
    sel = 0; reqAddr = 32'h30; reqBe = 4'hF; reqRen = 1'b1;
    @(posedge clk); #1;
    sawLow = !curBusy;
    @(posedge clk); #1;
    sawLow |= !curBusy;
    reqRen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      sawLow |= !curBusy;
    end
    checkOutput("abort no completion", 32'(sawLow), 32'h0);
    applyStimulus(0, 32'h30, 32'h0, 4'hF, 1'b1, 1'b0, rd, lat);
    checkLatency("after abort latency", lat, LAT_A);
    checkOutput("after abort rdata", rd, 32'h30303030);

    // Reset during the wait phase of a write must discard it.
    @(negedge clk);
    sel = 0; reqAddr = 32'h40; reqWdata = 32'h5; reqBe = 4'hF; reqWen = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset mid-write busy", 32'(busA.busy), 32'h1);
    checkOutput("reset mid-write rdata", busA.rdata, 32'h0);
    rst = 1'b0;
    reqWen = 1'b0;
    applyStimulus(0, 32'h40, 32'h0, 4'hF, 1'b1, 1'b0, rd, lat);
    checkOutput("reset mid-write mem", rd, 32'h40404040);

    // Zero-latency instance with a non-zero base address.
    applyStimulus(1, BASE_B + 32'h8, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b1, rd, lat);
    checkLatency("B write latency", lat, LAT_B);
    applyStimulus(1, BASE_B + 32'h8, 32'h0, 4'hF, 1'b1, 1'b0, rd, lat);
    checkLatency("B read latency", lat, LAT_B);
    checkOutput("B read rdata", rd, 32'hA5A5A5A5);
    applyStimulus(1, 32'h8, 32'h0, 4'hF, 1'b1, 1'b0, rd, lat);
    checkOutput("B below base", rd, BAD);
    applyStimulus(1, BASE_B, 32'h0, 4'hF, 1'b0, 1'b1, rd, lat);
    applyStimulus(1, BASE_B + 32'h40, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, rd, lat);
    applyStimulus(1, BASE_B + 32'h40, 32'h0, 4'hF, 1'b1, 1'b0, rd, lat);
    checkOutput("B above top", rd, BAD);
    applyStimulus(1, BASE_B, 32'h0, 4'hF, 1'b1, 1'b0, rd, lat);
    checkOutput("B dropped write", rd, 32'h0);

    // Randomized traffic against a word-array model.
    for (int w = 0; w < 32; w++) begin
      modelMem[w] = $urandom;
      applyStimulus(0, 32'(w * 4), modelMem[w], 4'hF, 1'b0, 1'b1, rd, lat);
      checkLatency($sformatf("init%0d latency", w), lat, LAT_A);
    end
    for (int n = 0; n < 300; n++) begin
      int          idx;
      int          op;
      logic        oor;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      idx = $urandom_range(0, 31);
      oor = ($urandom_range(0, 7) == 0);
      op  = $urandom_range(0, 2);
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      a   = oor ? (32'h1000 + 32'($urandom_range(0, 255)) * 4) : 32'(idx * 4);
      a[1:0] = 2'($urandom_range(0, 3));
      applyStimulus(0, a, d, be, (op != 1), (op != 0), rd, lat);
      checkLatency($sformatf("rand%0d latency", n), lat, LAT_A);
      if (op != 1) checkOutput($sformatf("rand%0d rdata", n), rd, oor ? BAD : modelMem[idx]);
      if (op != 0 && !oor)
        for (int b = 0; b < 4; b++)
          if (be[b]) modelMem[idx][8*b +: 8] = d[8*b +: 8];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
